// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: access lengths, FSM states
// and the default I/O-mapped address window.
package mem_ctrl_pkg;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  localparam logic [31:0] IO_ADDR_LO_DEF = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_HI_DEF = 32'h0003_0007;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    LOAD   = 2'd2,
    STORE  = 2'd3
  } state_t;

  // Bytes moved for a length code; the reserved code 3 behaves like a word.
  function automatic logic [2:0] xfer_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the LSB, the fetch unit, the RAM port and
// the memory controller (slave = controller side).
interface mem_ctrl_if;

  logic        lsb_read_signal;
  logic        lsb_write_signal;
  logic [1:0]  requiring_length;
  logic [31:0] to_mem_addr;
  logic [31:0] to_mem_data;
  logic        mem_load_success;
  logic        mem_store_success;
  logic [31:0] from_mem_data;
  logic        if_read;
  logic [31:0] if_addr;
  logic        if_success;
  logic [31:0] if_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  lsb_read_signal, lsb_write_signal, requiring_length, to_mem_addr,
           to_mem_data, if_read, if_addr, mem_din,
    output mem_load_success, mem_store_success, from_mem_data, if_success,
           if_data, mem_dout, mem_a, mem_wr
  );

  modport master (
    output lsb_read_signal, lsb_write_signal, requiring_length, to_mem_addr,
           to_mem_data, if_read, if_addr, mem_din,
    input  mem_load_success, mem_store_success, from_mem_data, if_success,
           if_data, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: serialises LSB loads/stores and instruction fetches onto
// a byte-wide RAM with one-cycle read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_ADDR_LO = IO_ADDR_LO_DEF,
  parameter logic [31:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      jump_wrong,
  input  logic      io_buffer_full,
  mem_ctrl_if.slave bus
);

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [2:0]  len_r;
  logic [31:0] base_r;
  logic [31:0] wdata_r;
  logic [31:0] buf_r;
  logic [31:0] mem_a_r;
  logic [7:0]  mem_dout_r;
  logic        mem_wr_r;
  logic        ld_ok_r;
  logic        st_ok_r;
  logic        if_ok_r;
  logic [31:0] ld_data_r;
  logic [31:0] if_data_r;

  logic        accept_s;
  logic        stall_s;
  logic [2:0]  wr_idx_s;
  logic [2:0]  ld_next_s;
  logic [31:0] wr_base_s;
  logic [31:0] wr_src_s;
  logic [31:0] wr_addr_s;
  logic [7:0]  wr_byte_s;
  logic [31:0] asm_s;

  // Acceptance gate and the next store byte; in STORE a high mem_wr means the
  // current byte is being written this cycle, so the next one is due.
  always_comb begin
    accept_s = (state_r == IDLE) && !(ld_ok_r || st_ok_r || if_ok_r) && !jump_wrong;
    if (state_r == IDLE) begin
      wr_idx_s  = 3'd0;
      wr_base_s = bus.to_mem_addr;
      wr_src_s  = bus.to_mem_data;
    end else begin
      wr_idx_s  = cnt_r + {2'b00, mem_wr_r};
      wr_base_s = base_r;
      wr_src_s  = wdata_r;
    end
    wr_addr_s = wr_base_s + {29'd0, wr_idx_s};
    wr_byte_s = wr_src_s[{wr_idx_s[1:0], 3'b000} +: 8];
    stall_s   = io_buffer_full && (wr_addr_s >= IO_ADDR_LO) && (wr_addr_s <= IO_ADDR_HI);
    ld_next_s = cnt_r + 3'd1;
  end

  // Merge the byte currently on mem_din (address issued two edges ago) into the word
  always_comb begin
    asm_s = buf_r;
    case (cnt_r)
      3'd1:    asm_s[7:0]   = bus.mem_din;
      3'd2:    asm_s[15:8]  = bus.mem_din;
      3'd3:    asm_s[23:16] = bus.mem_din;
      3'd4:    asm_s[31:24] = bus.mem_din;
      default: asm_s        = buf_r;
    endcase
  end

  // Transfer FSM with registered RAM-side and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      len_r      <= 3'd0;
      base_r     <= 32'd0;
      wdata_r    <= 32'd0;
      buf_r      <= 32'd0;
      mem_a_r    <= 32'd0;
      mem_dout_r <= 8'd0;
      mem_wr_r   <= 1'b0;
      ld_ok_r    <= 1'b0;
      st_ok_r    <= 1'b0;
      if_ok_r    <= 1'b0;
      ld_data_r  <= 32'd0;
      if_data_r  <= 32'd0;
    end else if (rdy) begin
      ld_ok_r <= 1'b0;
      st_ok_r <= 1'b0;
      if_ok_r <= 1'b0;
      case (state_r)
        IDLE: begin
          mem_wr_r <= 1'b0;
          cnt_r    <= 3'd0;
          buf_r    <= 32'd0;
          if (accept_s && bus.lsb_write_signal) begin
            state_r    <= STORE;
            base_r     <= bus.to_mem_addr;
            wdata_r    <= bus.to_mem_data;
            len_r      <= xfer_bytes(bus.requiring_length);
            mem_a_r    <= wr_addr_s;
            mem_dout_r <= wr_byte_s;
            mem_wr_r   <= !stall_s;
          end else if (accept_s && bus.lsb_read_signal) begin
            state_r <= LOAD;
            base_r  <= bus.to_mem_addr;
            len_r   <= xfer_bytes(bus.requiring_length);
            mem_a_r <= bus.to_mem_addr;
          end else if (accept_s && bus.if_read) begin
            state_r <= IFETCH;
            base_r  <= bus.if_addr;
            len_r   <= 3'd4;
            mem_a_r <= bus.if_addr;
          end
        end
        IFETCH, LOAD: begin
          if (jump_wrong) begin
            state_r <= IDLE;
          end else if (cnt_r == len_r) begin
            state_r <= IDLE;
            if (state_r == IFETCH) begin
              if_ok_r   <= 1'b1;
              if_data_r <= asm_s;
            end else begin
              ld_ok_r   <= 1'b1;
              ld_data_r <= asm_s;
            end
          end else begin
            buf_r <= asm_s;
            cnt_r <= ld_next_s;
            if (ld_next_s < len_r) begin
              mem_a_r <= base_r + {29'd0, ld_next_s};
            end
          end
        end
        STORE: begin
          // A committed store ignores jump_wrong and runs to completion.
          if (wr_idx_s == len_r) begin
            state_r  <= IDLE;
            mem_wr_r <= 1'b0;
            st_ok_r  <= 1'b1;
          end else begin
            cnt_r      <= wr_idx_s;
            mem_a_r    <= wr_addr_s;
            mem_dout_r <= wr_byte_s;
            mem_wr_r   <= !stall_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.mem_a             = mem_a_r;
  assign bus.mem_dout          = mem_dout_r;
  assign bus.mem_wr            = mem_wr_r;
  assign bus.mem_load_success  = ld_ok_r;
  assign bus.mem_store_success = st_ok_r;
  assign bus.if_success        = if_ok_r;
  assign bus.from_mem_data     = ld_data_r;
  assign bus.if_data           = if_data_r;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_ADDR_LO, default 32'h0003_0000, meaning lowest I/O-mapped byte address.
REQ-002 SHALL have parameter IO_ADDR_HI, default 32'h0003_0007, meaning highest I/O-mapped byte address.
REQ-003 SHALL have port: clk  in  1  clock; all logic on posedge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: rdy  in  1  global enable; low freezes all state and outputs.
REQ-006 SHALL have port: jump_wrong  in  1  misprediction flush.
REQ-007 SHALL have port: io_buffer_full  in  1  I/O write buffer full.
REQ-008 SHALL have ports: lsb_read_signal  in  1  and  lsb_write_signal  in  1  LSB level requests, held until success.
REQ-009 SHALL have ports: requiring_length  in  2  (0=byte, 1=half, 2=word)  and  to_mem_addr  in  32  and  to_mem_data  in  32.
REQ-010 SHALL have ports: mem_load_success  out  1  and  mem_store_success  out  1  one-cycle pulses;  from_mem_data  out  32  loaded data, zero-extended.
REQ-011 SHALL have ports: if_read  in  1  fetch request;  if_addr  in  32;  if_success  out  1  pulse;  if_data  out  32  instruction.
REQ-012 SHALL have ports: mem_din  in  8  RAM read byte;  mem_dout  out  8;  mem_a  out  32;  mem_wr  out  1  (1=write).

Function
REQ-013 SHALL implement FSM with states IDLE, IFETCH, LOAD, STORE.
REQ-014 In IDLE, SHALL accept in priority order: lsb_write_signal, lsb_read_signal, if_read.
REQ-015 SHALL NOT accept a request in any cycle where it drives a success pulse (one idle cycle after each transfer).
REQ-016 SHALL transfer N = 1/2/4 bytes for length codes 0/1/2; fetch always 4; length code 3 treated as 4.
REQ-017 Byte k SHALL use address base+k, little-endian (byte 0 -> bits 7:0), with 32-bit wrap-around.
REQ-018 RAM read latency: mem_din in cycle t+1 is the byte at mem_a in cycle t.
REQ-019 Load/fetch accepted at edge E0: mem_a=base from E0; byte k captured at E(k+2); success pulse and data valid in the cycle after E(N+1); word load latency = 5 cycles.
REQ-020 Store accepted at E0: byte k driven with mem_wr=1 from E(k); mem_store_success pulses in the cycle after E(N); mem_wr=0 otherwise.
REQ-021 Store byte whose address lies in [IO_ADDR_LO, IO_ADDR_HI] SHALL stall (mem_wr=0, counter held) while io_buffer_full=1.
REQ-022 jump_wrong=1 at an edge in IFETCH or LOAD: return to IDLE, no success pulse, partial data discarded.
REQ-023 jump_wrong=1 during STORE: store completes normally (store is already committed).
REQ-024 jump_wrong=1 in IDLE: no request accepted that cycle.
REQ-025 Unused upper bytes of from_mem_data SHALL be zero; sign extension belongs to the LSB.
REQ-026 if_data and from_mem_data SHALL hold their value until the next success of the same kind.

Reset
REQ-027 rst at an edge overrides rdy and jump_wrong: state=IDLE; all outputs (success pulses, data, mem_a, mem_dout, mem_wr) = 0; byte counter = 0.
REQ-028 rst mid-transfer SHALL abort with no success pulse and no further RAM write.

Structure
REQ-029 Length codes, FSM state encoding and IO address bounds SHALL live in the shared define package.
REQ-030 SHALL be a single module; no sub-module is required.

Verification
REQ-031 Word load at 0x100 holding bytes 11,22,33,44 -> mem_load_success in the 5th cycle after acceptance, from_mem_data=0x44332211.
REQ-032 Half store 0xBEEF to 0x200 -> mem_wr=1 for 2 cycles, bytes EF,BE at 0x200/0x201, store success after 2 cycles.
REQ-033 if_read and lsb_read_signal asserted together -> load serviced first; fetch starts after one idle cycle.
REQ-034 Byte store to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those cycles, then write, success once.
REQ-035 jump_wrong during 3rd byte of a fetch -> no if_success, IDLE next cycle; jump_wrong during store -> store completes.
REQ-036 rst during a word load -> outputs 0, no success pulse, next request serviced normally.
